// File: rtl/pkt_fmt_pkg.sv
// Shared types and helpers for the packet formatter: FSM states, length codes,
// length decode and the "no channel" ID.
package pkt_fmt_pkg;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_COLLECT = 3'd1,
    ST_REQ     = 3'd2,
    ST_SEND    = 3'd3,
    ST_DONE    = 3'd4
  } fmt_state_e;

  localparam logic [2:0] LEN_4  = 3'd0;
  localparam logic [2:0] LEN_8  = 3'd1;
  localparam logic [2:0] LEN_16 = 3'd2;
  localparam logic [2:0] LEN_32 = 3'd3;
  localparam logic [2:0] LEN_64 = 3'd4;

  // Widest channel-ID field (CH_NUM up to 7); narrower IDs take the low bits.
  localparam int unsigned MAX_IDW = 3;
  localparam logic [MAX_IDW-1:0] NO_CH = '1;

  // Map a length code to a beat count, never exceeding the buffer depth.
  function automatic int unsigned len_decode(input logic [2:0] sel,
                                             input int unsigned max_len);
    int unsigned len;
    case (sel)
      LEN_4:   len = 32'd4;
      LEN_8:   len = 32'd8;
      LEN_16:  len = 32'd16;
      LEN_32:  len = 32'd32;
      LEN_64:  len = 32'd64;
      default: len = max_len;
    endcase
    if (len > max_len) len = max_len;
    return len;
  endfunction

endpackage

// File: rtl/fmt_skid_buf.sv
// One-entry skid buffer holding a beat that arrived while the formatter was
// not accepting its channel.
module fmt_skid_buf #(
  parameter int unsigned DW = 8
) (
  input  logic          clk_i,
  input  logic          rstn_i,
  input  logic          push_i,
  input  logic          pop_i,
  input  logic [DW-1:0] data_i,
  output logic [DW-1:0] data_o,
  output logic          full_o
);

  // Push wins over pop so a simultaneous drain-and-refill keeps the entry full.
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      full_o <= 1'b0;
      data_o <= '0;
    end else if (push_i) begin
      full_o <= 1'b1;
      data_o <= data_i;
    end else if (pop_i) begin
      full_o <= 1'b0;
    end
  end

endmodule

// File: rtl/pkt_formatter_p.sv
// Packet formatter: collects one channel's packet into a local buffer, then
// bursts it to the output interface with start/end framing and backpressure.
module pkt_formatter_p
  import pkt_fmt_pkg::*;
#(
  parameter int unsigned CH_NUM  = 3,
  parameter int unsigned DW      = 8,
  parameter int unsigned MAX_LEN = 64,
  parameter int unsigned IDW     = $clog2(CH_NUM + 1)
) (
  input  logic           clk_i,
  input  logic           rstn_i,
  output logic           fmt_id_req_o,
  output logic           f2a_ack_o,
  input  logic           a2f_val_i,
  input  logic [IDW-1:0] a2f_id_i,
  input  logic [DW-1:0]  a2f_data_i,
  input  logic [2:0]     pkglen_sel_i,
  input  logic           fmt_grant_i,
  input  logic           fmt_rdy_i,
  output logic           fmt_req_o,
  output logic [IDW-1:0] fmt_chid_o,
  output logic [31:0]    fmt_length_o,
  output logic [DW-1:0]  fmt_data_o,
  output logic           fmt_vld_o,
  output logic           fmt_start_o,
  output logic           fmt_end_o,
  output logic           err_ovf_o
);

  localparam int unsigned PW = $clog2(MAX_LEN) + 1;
  localparam logic [IDW-1:0] NO_ID = IDW'(NO_CH);

  fmt_state_e state_q, state_d;

  logic [IDW-1:0] ch_q;
  logic [PW-1:0]  len_q;
  logic [PW-1:0]  wr_ptr_q;
  logic [PW-1:0]  rd_ptr_q;
  logic           err_q;
  logic [DW-1:0]  mem [MAX_LEN];

  logic [CH_NUM-1:0] skid_full;
  logic [CH_NUM-1:0] skid_push;
  logic [CH_NUM-1:0] skid_pop;
  logic [DW-1:0]     skid_data [CH_NUM];

  logic          id_ok;
  logic          in_beat;
  logic          collecting;
  logic          cur_full;
  logic [DW-1:0] cur_data;
  logic          skid_wr;
  logic          a2f_wr;
  logic          wr_en;
  logic [DW-1:0] wr_data;
  logic          last_wr;
  logic          last_rd;
  logic          ovf;

  assign id_ok      = (a2f_id_i < IDW'(CH_NUM));
  assign in_beat    = a2f_val_i && id_ok;
  assign collecting = (state_q == ST_COLLECT);

  // Skid entry belonging to the channel being collected.
  always_comb begin
    cur_full = 1'b0;
    cur_data = '0;
    for (int i = 0; i < CH_NUM; i++) begin
      if (ch_q == IDW'(i)) begin
        cur_full = skid_full[i];
        cur_data = skid_data[i];
      end
    end
  end

  // A held skid beat always goes into the buffer ahead of new arbiter data.
  assign skid_wr   = collecting && cur_full;
  assign a2f_wr    = collecting && !cur_full && in_beat && (a2f_id_i == ch_q);
  assign wr_en     = skid_wr || a2f_wr;
  assign wr_data   = skid_wr ? cur_data : a2f_data_i;
  assign last_wr   = wr_en && (wr_ptr_q == len_q - PW'(1));
  assign last_rd   = (rd_ptr_q == len_q - PW'(1));
  assign f2a_ack_o = collecting && !last_wr;

  // Any valid beat not written to the buffer lands in its channel's skid.
  always_comb begin
    skid_push = '0;
    skid_pop  = '0;
    ovf       = 1'b0;
    for (int i = 0; i < CH_NUM; i++) begin
      skid_pop[i] = skid_wr && (ch_q == IDW'(i));
      if (in_beat && (a2f_id_i == IDW'(i)) && !a2f_wr) begin
        if (!skid_full[i] || skid_pop[i]) skid_push[i] = 1'b1;
        else                              ovf          = 1'b1;
      end
    end
  end

  for (genvar g = 0; g < CH_NUM; g++) begin : g_skid
    fmt_skid_buf #(.DW(DW)) u_skid (
      .clk_i  (clk_i),
      .rstn_i (rstn_i),
      .push_i (skid_push[g]),
      .pop_i  (skid_pop[g]),
      .data_i (a2f_data_i),
      .data_o (skid_data[g]),
      .full_o (skid_full[g])
    );
  end

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) state_q <= ST_IDLE;
    else         state_q <= state_d;
  end

  // Next state and state-decoded outputs.
  always_comb begin
    state_d      = state_q;
    fmt_id_req_o = 1'b0;
    fmt_req_o    = 1'b0;
    fmt_vld_o    = 1'b0;
    fmt_start_o  = 1'b0;
    fmt_end_o    = 1'b0;
    fmt_data_o   = '0;
    case (state_q)
      ST_IDLE: begin
        fmt_id_req_o = 1'b1;
        if (id_ok) state_d = ST_COLLECT;
      end
      ST_COLLECT: begin
        if (last_wr) state_d = ST_REQ;
      end
      ST_REQ: begin
        fmt_req_o = 1'b1;
        if (fmt_grant_i) state_d = ST_SEND;
      end
      ST_SEND: begin
        fmt_vld_o   = 1'b1;
        fmt_data_o  = mem[rd_ptr_q[PW-2:0]];
        fmt_start_o = (rd_ptr_q == '0);
        fmt_end_o   = last_rd;
        if (fmt_rdy_i && last_rd) state_d = ST_DONE;
      end
      ST_DONE: begin
        fmt_id_req_o = 1'b1;
        state_d      = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      ch_q     <= NO_ID;
      len_q    <= PW'(MAX_LEN);
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      err_q    <= 1'b0;
    end else begin
      if (state_q == ST_IDLE && id_ok) begin
        ch_q     <= a2f_id_i;
        len_q    <= PW'(len_decode(pkglen_sel_i, MAX_LEN));
        wr_ptr_q <= '0;
        rd_ptr_q <= '0;
      end
      if (wr_en) wr_ptr_q <= wr_ptr_q + PW'(1);
      if (state_q == ST_SEND && fmt_rdy_i) rd_ptr_q <= rd_ptr_q + PW'(1);
      if (ovf) err_q <= 1'b1;
    end
  end

  // Packet storage; contents are only read after being written.
  always_ff @(posedge clk_i) begin
    if (wr_en) mem[wr_ptr_q[PW-2:0]] <= wr_data;
  end

  assign fmt_chid_o   = ch_q;
  assign fmt_length_o = 32'(len_q);
  assign err_ovf_o    = err_q;

endmodule

// File: tb/tb_pkt_formatter_p.sv
// Self-checking bench for pkt_formatter_p (3 channels, 8-bit data, 32-beat buffer).
`timescale 1ns/1ps
module tb_pkt_formatter_p;

  localparam int CH = 3;
  localparam int ML = 32;
  localparam logic [1:0] NOID = 2'b11;

  logic       clk_i = 1'b0;
  logic       rstn_i;
  logic       fmt_id_req_o, f2a_ack_o;
  logic       a2f_val_i;
  logic [1:0] a2f_id_i;
  logic [7:0] a2f_data_i;
  logic [2:0] pkglen_sel_i;
  logic       fmt_grant_i, fmt_rdy_i;
  logic       fmt_req_o;
  logic [1:0] fmt_chid_o;
  logic [31:0] fmt_length_o;
  logic [7:0] fmt_data_o;
  logic       fmt_vld_o, fmt_start_o, fmt_end_o, err_ovf_o;

  pkt_formatter_p #(.CH_NUM(3), .DW(8), .MAX_LEN(ML)) dut (
    .clk_i(clk_i), .rstn_i(rstn_i), .fmt_id_req_o(fmt_id_req_o), .f2a_ack_o(f2a_ack_o),
    .a2f_val_i(a2f_val_i), .a2f_id_i(a2f_id_i), .a2f_data_i(a2f_data_i),
    .pkglen_sel_i(pkglen_sel_i), .fmt_grant_i(fmt_grant_i), .fmt_rdy_i(fmt_rdy_i),
    .fmt_req_o(fmt_req_o), .fmt_chid_o(fmt_chid_o), .fmt_length_o(fmt_length_o),
    .fmt_data_o(fmt_data_o), .fmt_vld_o(fmt_vld_o), .fmt_start_o(fmt_start_o),
    .fmt_end_o(fmt_end_o), .err_ovf_o(err_ovf_o)
  );

  always #5 clk_i = ~clk_i;

  int n_cmp = 0;
  int n_fail = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference model: per-channel single pending beat, the packet being
  // gathered, and the list of beats the output must show in order.
  typedef struct packed {
    logic [7:0]  d;
    logic        s;
    logic        e;
    logic [1:0]  ch;
    logic [31:0] len;
  } beat_t;

  beat_t      exp_q[$];
  logic [7:0] col_q[$];
  logic       pend_v[CH];
  logic [7:0] pend_d[CH];
  logic       col_act;
  int         cur_ch, cur_len;
  logic       exp_err;

  function automatic int mlen(input int sel);
    int l;
    l = (sel <= 4) ? (4 << sel) : ML;
    return (l > ML) ? ML : l;
  endfunction

  task automatic model_reset();
    exp_q.delete();
    col_q.delete();
    for (int c = 0; c < CH; c++) begin pend_v[c] = 1'b0; pend_d[c] = 8'h0; end
    col_act = 1'b0;
    exp_err = 1'b0;
  endtask

  task automatic model_start(input int id, input int sel);
    col_act = 1'b1;
    cur_ch  = id;
    cur_len = mlen(sel);
    col_q.delete();
    if (pend_v[id]) begin col_q.push_back(pend_d[id]); pend_v[id] = 1'b0; end
  endtask

  task automatic model_beat(input int id, input logic [7:0] d);
    if (col_act && id == cur_ch) begin
      col_q.push_back(d);
      if (col_q.size() >= cur_len) begin
        for (int k = 0; k < cur_len; k++)
          exp_q.push_back('{d: col_q[k], s: (k == 0), e: (k == cur_len - 1),
                            ch: 2'(cur_ch), len: 32'(cur_len)});
        if (col_q.size() > cur_len) begin
          pend_v[id] = 1'b1;
          pend_d[id] = col_q[cur_len];
        end
        col_act = 1'b0;
      end
    end else if (pend_v[id]) begin
      exp_err = 1'b1;
    end else begin
      pend_v[id] = 1'b1;
      pend_d[id] = d;
    end
  endtask

  // Output compare process: every presented beat against the model's head.
  int         xfer_cnt = 0;
  logic [7:0] first_d = 8'h0;
  logic [7:0] last_d = 8'h0;

  always @(negedge clk_i) begin
    if (rstn_i === 1'b1 && fmt_vld_o === 1'b1) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_vld", 32'(fmt_vld_o), 32'd0);
      end else begin
        chk("out_data",  32'(fmt_data_o),  32'(exp_q[0].d));
        chk("out_start", 32'(fmt_start_o), 32'(exp_q[0].s));
        chk("out_end",   32'(fmt_end_o),   32'(exp_q[0].e));
        chk("out_chid",  32'(fmt_chid_o),  32'(exp_q[0].ch));
        chk("out_len",   fmt_length_o,     exp_q[0].len);
        if (fmt_rdy_i) begin
          if (exp_q[0].s) first_d = fmt_data_o;
          if (exp_q[0].e) last_d = fmt_data_o;
          xfer_cnt++;
          void'(exp_q.pop_front());
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic run_pkt(input int id, input int sel, input logic [7:0] base,
                         input int n, input bit ackchk);
    a2f_id_i     = 2'(id);
    pkglen_sel_i = 3'(sel);
    a2f_val_i    = 1'b0;
    model_start(id, sel);
    tick();
    for (int k = 0; k < n; k++) begin
      a2f_val_i  = 1'b1;
      a2f_data_i = 8'(base + 8'(k));
      model_beat(id, a2f_data_i);
      if (ackchk) begin
        @(negedge clk_i);
        chk("collect_ack", 32'(f2a_ack_o), (k == n - 1) ? 32'd0 : 32'd1);
      end
      tick();
    end
    a2f_val_i = 1'b0;
    a2f_id_i  = NOID;
  endtask

  // Grant the output, then drain with optional backpressure or injections.
  // inj: 0 none, 1 skid beats during SEND, 2 reset after 5 beats.
  task automatic serve(input int gdelay, input bit toggle, input int inj);
    int w, i, base;
    w = 0;
    while (fmt_req_o !== 1'b1 && w < 400) begin tick(); w++; end
    chk("req_seen", 32'(fmt_req_o), 32'd1);
    repeat (gdelay) tick();
    fmt_grant_i = 1'b1;
    @(negedge clk_i);
    chk("req_before_grant", 32'({fmt_req_o, fmt_vld_o}), 32'b10);
    tick();
    fmt_grant_i = 1'b0;
    @(negedge clk_i);
    chk("grant_latency", 32'(fmt_vld_o), 32'd1);
    tick();
    base = xfer_cnt;
    i = 0;
    while (exp_q.size() > 0 && i < 200) begin
      fmt_rdy_i = toggle ? ~i[0] : 1'b1;
      if (inj == 1) begin
        a2f_val_i = 1'b0;
        a2f_id_i  = NOID;
        if (i == 0) begin
          a2f_val_i = 1'b1; a2f_id_i = 2'd2; a2f_data_i = 8'h55;
          model_beat(2, 8'h55);
        end
        if (i == 2) begin
          chk("ovf_clear_after_one", 32'(err_ovf_o), 32'd0);
          a2f_val_i = 1'b1; a2f_id_i = 2'd2; a2f_data_i = 8'h66;
          model_beat(2, 8'h66);
        end
      end
      if (inj == 2 && xfer_cnt - base == 5) begin
        rstn_i = 1'b0;
        model_reset();
        #1;
        chk("rst_vld",   32'({fmt_vld_o, fmt_start_o, fmt_end_o, fmt_req_o}), 32'd0);
        chk("rst_idreq", 32'({fmt_id_req_o, f2a_ack_o, err_ovf_o}), 32'b100);
        chk("rst_chid",  32'(fmt_chid_o), 32'(NOID));
        chk("rst_len",   fmt_length_o, 32'(ML));
        chk("rst_data",  32'(fmt_data_o), 32'd0);
        tick(); tick();
        rstn_i = 1'b1;
        tick();
        chk("post_rst_idreq", 32'(fmt_id_req_o), 32'd1);
        fmt_rdy_i = 1'b1;
        return;
      end
      tick();
      i++;
    end
    a2f_val_i = 1'b0;
    a2f_id_i  = NOID;
    fmt_rdy_i = 1'b1;
    chk("drain_done", 32'(exp_q.size()), 32'd0);
    w = 0;
    while (fmt_id_req_o !== 1'b1 && w < 20) begin tick(); w++; end
    chk("done_idreq", 32'(fmt_id_req_o), 32'd1);
    tick(); tick();
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  int b0;

  initial begin
    rstn_i = 1'b0; a2f_val_i = 1'b0; a2f_id_i = NOID; a2f_data_i = 8'h0;
    pkglen_sel_i = 3'd0; fmt_grant_i = 1'b0; fmt_rdy_i = 1'b1;
    model_reset();
    @(negedge clk_i);
    chk("reset_idreq", 32'(fmt_id_req_o), 32'd1);
    chk("reset_ctrl",  32'({f2a_ack_o, fmt_req_o, fmt_vld_o, fmt_start_o, fmt_end_o, err_ovf_o}), 32'd0);
    chk("reset_chid",  32'(fmt_chid_o), 32'h3);
    chk("reset_len",   fmt_length_o, 32'd32);
    chk("reset_data",  32'(fmt_data_o), 32'd0);
    tick(); tick();
    rstn_i = 1'b1;
    tick();

    // No channel offered: formatter must stay idle.
    for (int k = 0; k < 10; k++) begin
      @(negedge clk_i);
      chk("no_channel_idle", 32'({f2a_ack_o, fmt_req_o, fmt_vld_o, fmt_id_req_o}), 32'b0001);
      tick();
    end

    // Basic 4-beat packet on channel 1.
    b0 = xfer_cnt;
    run_pkt(1, 0, 8'hA0, 4, 1'b1);
    serve(2, 1'b0, 0);
    chk("basic_chid",  32'(fmt_chid_o), 32'd1);
    chk("basic_len",   fmt_length_o, 32'd4);
    chk("basic_first", 32'(first_d), 32'hA0);
    chk("basic_last",  32'(last_d), 32'hA3);
    chk("basic_count", 32'(xfer_cnt - b0), 32'd4);

    // 16-beat packet under alternating backpressure.
    b0 = xfer_cnt;
    run_pkt(0, 2, 8'h10, 16, 1'b0);
    serve(1, 1'b1, 0);
    chk("bp_len",   fmt_length_o, 32'd16);
    chk("bp_count", 32'(xfer_cnt - b0), 32'd16);
    chk("bp_last",  32'(last_d), 32'h1F);

    // Skid: 0x55 held for channel 2, 0x66 overflows.
    run_pkt(1, 1, 8'h30, 8, 1'b0);
    serve(0, 1'b0, 1);
    chk("ovf_set", 32'(err_ovf_o), 32'd1);
    chk("ovf_model", 32'(err_ovf_o), 32'(exp_err));
    b0 = xfer_cnt;
    run_pkt(2, 0, 8'h67, 3, 1'b0);
    serve(1, 1'b0, 0);
    chk("skid_first", 32'(first_d), 32'h55);
    chk("skid_last",  32'(last_d), 32'h69);
    chk("skid_count", 32'(xfer_cnt - b0), 32'd4);

    // Length codes beyond the buffer depth clip to 32 beats.
    b0 = xfer_cnt;
    run_pkt(0, 4, 8'h00, 32, 1'b0);
    serve(0, 1'b0, 0);
    chk("clip4_len",   fmt_length_o, 32'd32);
    chk("clip4_count", 32'(xfer_cnt - b0), 32'd32);
    b0 = xfer_cnt;
    run_pkt(1, 7, 8'h40, 32, 1'b0);
    serve(0, 1'b0, 0);
    chk("clip7_len",   fmt_length_o, 32'd32);
    chk("clip7_count", 32'(xfer_cnt - b0), 32'd32);
    chk("clip7_last",  32'(last_d), 32'h5F);

    // Reset in the middle of an 8-beat burst, then a clean packet.
    run_pkt(2, 1, 8'h80, 8, 1'b0);
    serve(0, 1'b0, 2);
    b0 = xfer_cnt;
    run_pkt(1, 0, 8'hC0, 4, 1'b1);
    serve(1, 1'b0, 0);
    chk("after_rst_first", 32'(first_d), 32'hC0);
    chk("after_rst_last",  32'(last_d), 32'hC3);
    chk("after_rst_count", 32'(xfer_cnt - b0), 32'd4);
    chk("after_rst_err",   32'(err_ovf_o), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
